// File: rtl/seg7_display_ctrl_if.sv
// Write-side bus of the seven-segment controller: value, format flags and busy handshake.
`timescale 1ns/1ps
interface seg7_display_ctrl_if #(
    parameter int DATA_W = 16
);
    logic              we_i;
    logic [DATA_W-1:0] data_i;
    logic              mode_i;
    logic              blank_lz_i;
    logic              busy_o;

    modport master (output we_i, data_i, mode_i, blank_lz_i, input busy_o);
    modport slave  (input we_i, data_i, mode_i, blank_lz_i, output busy_o);
endinterface

// File: rtl/seg7_display_ctrl.sv
// Seven-segment controller: hex or double-dabble decimal rendering onto a static
// per-digit bus and a scanned segment/anode pair.
`timescale 1ns/1ps
module seg7_display_ctrl #(
    parameter int DIGITS     = 4,
    parameter int DATA_W     = 16,
    parameter int CLK_DIV    = 5000,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic                  clk_i,
    input  logic                  reset,
    seg7_display_ctrl_if.slave    bus,
    output logic [7*DIGITS-1:0]   hex_o,
    output logic [6:0]            seg_o,
    output logic [DIGITS-1:0]     an_o
);
    localparam int NW     = 4 * DIGITS;
    localparam int STEP_W = $clog2(DATA_W + 1);
    localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [63:0] DEC_LIMIT = 64'(10 ** DIGITS);

    typedef enum logic [1:0] {IDLE, CONV, COMMIT} state_t;

    state_t              state_q, state_d;
    logic [NW-1:0]       nib_q;
    logic [DIGITS-1:0]   blank_q, dash_q;
    logic [DATA_W-1:0]   bin_q;
    logic [NW-1:0]       bcd_q;
    logic [STEP_W-1:0]   step_q;
    logic                ovf_q, blz_q;
    logic [DIV_W-1:0]    div_q;
    logic [IDX_W-1:0]    idx_q;
    logic [DIGITS-1:0]   anSel;

    function automatic logic [NW-1:0] dabbleStep(input logic [NW-1:0] bcd, input logic inBit);
        logic [NW-1:0] adj;
        adj = bcd;
        for (int k = 0; k < DIGITS; k++)
            if (bcd[4*k +: 4] >= 4'd5) adj[4*k +: 4] = bcd[4*k +: 4] + 4'd3;
        return {adj[NW-2:0], inBit};
    endfunction

    // Blank zeros above the most significant nonzero digit; digit 0 always stays lit.
    function automatic logic [DIGITS-1:0] leadBlank(input logic [NW-1:0] nib, input logic lz);
        logic [DIGITS-1:0] b;
        logic              seen;
        b    = '0;
        seen = 1'b0;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            if (nib[4*k +: 4] != 4'd0) seen = 1'b1;
            b[k] = lz & ~seen;
        end
        return b;
    endfunction

    function automatic logic [6:0] segDecode(input logic [3:0] n);
        case (n)
            4'h0: return 7'h3F;  4'h1: return 7'h06;  4'h2: return 7'h5B;  4'h3: return 7'h4F;
            4'h4: return 7'h66;  4'h5: return 7'h6D;  4'h6: return 7'h7D;  4'h7: return 7'h07;
            4'h8: return 7'h7F;  4'h9: return 7'h6F;  4'hA: return 7'h77;  4'hB: return 7'h7C;
            4'hC: return 7'h39;  4'hD: return 7'h5E;  4'hE: return 7'h79;
            default: return 7'h71;
        endcase
    endfunction

    always_ff @(posedge clk_i or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.we_i && bus.mode_i) state_d = CONV;
            CONV:    if (step_q == STEP_W'(DATA_W - 1)) state_d = COMMIT;
            COMMIT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.busy_o = (state_q != IDLE);
    end

    // Writes are only sampled in IDLE, so a strobe during conversion simply falls through.
    always_ff @(posedge clk_i or posedge reset) begin
        if (reset) begin
            nib_q   <= '0;
            blank_q <= '0;
            dash_q  <= '0;
            bin_q   <= '0;
            bcd_q   <= '0;
            step_q  <= '0;
            ovf_q   <= 1'b0;
            blz_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (bus.we_i) begin
                    if (bus.mode_i) begin
                        bin_q  <= bus.data_i;
                        bcd_q  <= '0;
                        step_q <= '0;
                        ovf_q  <= (64'(bus.data_i) >= DEC_LIMIT);
                        blz_q  <= bus.blank_lz_i;
                    end else begin
                        nib_q   <= NW'(bus.data_i);
                        blank_q <= leadBlank(NW'(bus.data_i), bus.blank_lz_i);
                        dash_q  <= '0;
                    end
                end
                CONV: begin
                    bcd_q  <= dabbleStep(bcd_q, bin_q[DATA_W-1]);
                    bin_q  <= bin_q << 1;
                    step_q <= step_q + STEP_W'(1);
                end
                COMMIT: begin
                    nib_q   <= bcd_q;
                    blank_q <= ovf_q ? '0 : leadBlank(bcd_q, blz_q);
                    dash_q  <= {DIGITS{ovf_q}};
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        hex_o = '0;
        for (int k = 0; k < DIGITS; k++) begin
            if (dash_q[k])       hex_o[7*k +: 7] = 7'h40 ^ {7{ACTIVE_LOW}};
            else if (blank_q[k]) hex_o[7*k +: 7] = 7'h00 ^ {7{ACTIVE_LOW}};
            else                 hex_o[7*k +: 7] = segDecode(nib_q[4*k +: 4]) ^ {7{ACTIVE_LOW}};
        end
    end

    always_ff @(posedge clk_i or posedge reset) begin
        if (reset) begin
            div_q <= '0;
            idx_q <= '0;
        end else if (div_q == DIV_W'(CLK_DIV - 1)) begin
            div_q <= '0;
            idx_q <= (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
        end else begin
            div_q <= div_q + DIV_W'(1);
        end
    end

    // The scanned segments tap hex_o combinationally so mid-frame updates show at once.
    always_comb begin
        seg_o = '0;
        anSel = '0;
        for (int k = 0; k < DIGITS; k++) begin
            if (idx_q == IDX_W'(k)) begin
                seg_o    = hex_o[7*k +: 7];
                anSel[k] = 1'b1;
            end
        end
    end

    assign an_o = ACTIVE_LOW ? ~anSel : anSel;

endmodule

// File: tb/tb_seg7_display_ctrl.sv
// Randomised scoreboard bench for seg7_display_ctrl: the driver pushes the expected
// display per accepted write, a separate monitor checks it when the DUT delivers.
`timescale 1ns/1ps
module tb_seg7_display_ctrl;
    localparam int DIGITS     = 4;
    localparam int DATA_W     = 16;
    localparam int CLK_DIV    = 4;
    localparam bit ACTIVE_LOW = 1'b1;
    localparam int HW         = 7 * DIGITS;
    localparam logic [6:0] SEG_TABLE [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    typedef struct {
        logic [HW-1:0] expHex;
        bit            isDec;
    } sbItem_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [HW-1:0]     hexOut;
    logic [6:0]        segOut;
    logic [DIGITS-1:0] anOut;

    int      checks = 0;
    int      errors = 0;
    int      edgeCnt = 0;
    bit      monBusy = 1'b0;
    sbItem_t sbQ[$];
    sbItem_t item;
    int      busyCnt;
    logic [HW-1:0] shownHex;

    seg7_display_ctrl_if #(.DATA_W(DATA_W)) bus();

    seg7_display_ctrl #(
        .DIGITS(DIGITS), .DATA_W(DATA_W), .CLK_DIV(CLK_DIV), .ACTIVE_LOW(ACTIVE_LOW)
    ) dut (
        .clk_i(clk),
        .reset(reset),
        .bus(bus),
        .hex_o(hexOut),
        .seg_o(segOut),
        .an_o(anOut)
    );

    always #5 clk = ~clk;

    always @(posedge clk or posedge reset) begin
        if (reset) edgeCnt = 0;
        else       edgeCnt = edgeCnt + 1;
    end

    // Digit k of the rendered value is (value / base^k) mod base; it is a leading zero
    // exactly when value < base^k.
    function automatic logic [HW-1:0] modelDisplay(input int unsigned value, input bit isDec, input bit lz);
        int unsigned base, scale;
        logic [6:0]  segs;
        logic [HW-1:0] r;
        base  = isDec ? 10 : 16;
        scale = 1;
        r     = '0;
        for (int k = 0; k < DIGITS; k++) begin
            if (isDec && value >= 10 ** DIGITS) segs = 7'h40;
            else if (lz && k > 0 && value < scale) segs = 7'h00;
            else segs = SEG_TABLE[int'((value / scale) % base)];
            r[7*k +: 7] = ACTIVE_LOW ? ~segs : segs;
            scale = scale * base;
        end
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input bit isDec, input bit lz, input logic [15:0] value, input bit expectAccept);
        sbItem_t it;
        @(negedge clk);
        bus.we_i       = 1'b1;
        bus.data_i     = value;
        bus.mode_i     = isDec;
        bus.blank_lz_i = lz;
        if (expectAccept) begin
            it.expHex = modelDisplay(value, isDec, lz);
            it.isDec  = isDec;
            sbQ.push_back(it);
        end
        @(negedge clk);
        bus.we_i = 1'b0;
    endtask

    task automatic waitIdle();
        int n;
        n = 0;
        while ((sbQ.size() != 0 || monBusy) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            checks++;
            errors++;
            $display("[TB] FAIL idleTimeout actual=%0d expected<200", n);
        end
    endtask

    task automatic checkScan();
        int exIdx;
        logic [DIGITS-1:0] anExp;
        exIdx = (edgeCnt / CLK_DIV) % DIGITS;
        anExp = '0;
        anExp[exIdx] = 1'b1;
        if (ACTIVE_LOW) anExp = ~anExp;
        checkOutput("scanAn", 32'(anOut), 32'(anExp));
        checkOutput("scanSeg", 32'(segOut), 32'(shownHex[7*exIdx +: 7]));
    endtask

    initial begin : monitor
        forever begin
            wait (sbQ.size() > 0);
            item = sbQ.pop_front();
            monBusy = 1'b1;
            @(posedge clk);
            #1;
            if (!item.isDec) begin
                checkOutput("hexValue", 32'(hexOut), 32'(item.expHex));
                checkOutput("hexBusy", 32'(bus.busy_o), 32'd0);
            end else begin
                busyCnt = 0;
                while (bus.busy_o === 1'b1 && busyCnt < 100) begin
                    checkOutput("decHeld", 32'(hexOut), 32'(shownHex));
                    busyCnt++;
                    @(posedge clk);
                    #1;
                end
                checkOutput("decBusyCycles", 32'(busyCnt), 32'(DATA_W + 1));
                checkOutput("decValue", 32'(hexOut), 32'(item.expHex));
            end
            shownHex = item.expHex;
            monBusy  = 1'b0;
        end
    end

    initial begin : driver
        bit isDec, lz;
        logic [15:0] value;
        bus.we_i       = 1'b0;
        bus.data_i     = '0;
        bus.mode_i     = 1'b0;
        bus.blank_lz_i = 1'b0;
        shownHex = modelDisplay(0, 1'b0, 1'b0);

        repeat (3) @(negedge clk);
        checkOutput("resetHex", 32'(hexOut), 32'({DIGITS{7'b1000000}}));
        checkOutput("resetBusy", 32'(bus.busy_o), 32'd0);
        checkOutput("resetAn", 32'(anOut), 32'(4'b1110));
        checkOutput("resetSeg", 32'(segOut), 32'(7'b1000000));
        reset = 1'b0;
        repeat (12) begin
            @(negedge clk);
            checkScan();
        end

        applyStimulus(1'b0, 1'b1, 16'h00A3, 1'b1);
        waitIdle();
        applyStimulus(1'b1, 1'b1, 16'd50, 1'b1);
        waitIdle();
        applyStimulus(1'b1, 1'b0, 16'd12345, 1'b1);
        repeat (4) @(negedge clk);
        applyStimulus(1'b0, 1'b0, 16'd7, 1'b0);
        waitIdle();
        @(negedge clk);
        checkOutput("ignoredWrite", 32'(hexOut), 32'(shownHex));

        applyStimulus(1'b1, 1'b1, 16'd9999, 1'b1);  waitIdle();
        applyStimulus(1'b1, 1'b1, 16'd10000, 1'b1); waitIdle();
        applyStimulus(1'b1, 1'b1, 16'd0, 1'b1);     waitIdle();
        applyStimulus(1'b0, 1'b1, 16'h0000, 1'b1);  waitIdle();
        applyStimulus(1'b0, 1'b1, 16'hFFFF, 1'b1);  waitIdle();
        applyStimulus(1'b1, 1'b0, 16'hFFFF, 1'b1);  waitIdle();

        applyStimulus(1'b1, 1'b0, 16'd999, 1'b0);
        repeat (5) @(negedge clk);
        checkOutput("midConvBusy", 32'(bus.busy_o), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        shownHex = modelDisplay(0, 1'b0, 1'b0);
        checkOutput("midResetBusy", 32'(bus.busy_o), 32'd0);
        checkOutput("midResetHex", 32'(hexOut), 32'(shownHex));
        @(negedge clk);
        reset = 1'b0;
        applyStimulus(1'b1, 1'b0, 16'd4321, 1'b1);
        waitIdle();

        for (int i = 0; i < 30; i++) begin
            isDec = 1'($urandom_range(0, 1));
            lz    = 1'($urandom_range(0, 1));
            if (isDec)
                value = ($urandom_range(0, 2) == 0) ? 16'($urandom_range(10000, 65535))
                                                    : 16'($urandom_range(0, 9999));
            else
                value = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 255)) : 16'($urandom);
            applyStimulus(isDec, lz, value, 1'b1);
            if (isDec && $urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(1, 10)) @(negedge clk);
                applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 16'($urandom), 1'b0);
            end
            waitIdle();
        end

        repeat (2 * DIGITS * CLK_DIV) begin
            @(negedge clk);
            checkScan();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
